card_dealer: RTL and testbench



---
 rtl/card_pkg.sv | 21 ++
 rtl/card_dealer_hold_timer.sv | 46 ++++
 rtl/card_dealer.sv | 155 +++++++++++++++
 tb/tb_card_dealer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared definitions for the card dealer: state encoding, deck constants
// and the rank-to-blackjack-value mapping.
package card_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CHECK  = 3'd2,
    DEAL   = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam int NUM_RANKS = 13;
  localparam int DECK_SIZE = 52;

  // Ace counts 1, pips count face value, J/Q/K count 10.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd10 : rank;
  endfunction

endpackage

// File: rtl/card_dealer_hold_timer.sv
// Counts 2 kHz strobes after a start pulse and emits a single-cycle done
// pulse on the strobe that reaches HOLD_TICKS.
module hold_timer #(
  parameter int HOLD_TICKS = 4000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  input  logic start,
  input  logic i_Tick2K,
  output logic done
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(HOLD_TICKS);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          active_reg;
  logic          done_reg;

  assign count_next = count_reg + 1'b1;

  // start has priority so a strobe coinciding with it is not counted.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        count_reg  <= '0;
        active_reg <= 1'b1;
      end else if (active_reg && i_Tick2K) begin
        count_reg <= count_next;
        if (count_next == LAST_COUNT) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;

endmodule

// File: rtl/card_dealer.sv
// Deals ranks 1..13 from a 52-card deck using the low nibble of the game
// counter as entropy, then holds the result for a timed display window.
module card_dealer
  import card_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int HOLD_TICKS = 4000,
  parameter int MAX_COPIES = 4
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Tick2K,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Draw,
  input  logic             i_Shuffle,
  output logic [3:0]       o_Card,
  output logic [3:0]       o_Value,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_DeckEmpty,
  output logic             o_TwoSec
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_SAMPLE = 3'(SAMPLE);
  localparam logic [2:0] ST_CHECK  = 3'(CHECK);
  localparam logic [2:0] ST_DEAL   = 3'(DEAL);
  localparam logic [2:0] ST_HOLD   = 3'(HOLD);

  localparam logic [2:0] COPY_LIMIT = 3'(MAX_COPIES);
  localparam logic [5:0] DECK_FULL  = 6'(DECK_SIZE);
  localparam logic [3:0] LAST_CAND  = 4'(NUM_RANKS - 1);

  logic [2:0]           state_reg, state_next;
  logic [3:0]           cand_reg, cand_next;
  logic [5:0]           dealt_reg;
  logic [3:0]           card_reg;
  logic [3:0]           value_reg;
  logic                 valid_reg;
  logic                 deck_empty_reg;
  logic [NUM_RANKS-1:0] full_vec;
  logic                 cand_full;
  logic                 hold_done;
  logic [3:0]           raw;
  logic [3:0]           folded;
  logic                 shuffle_now;
  logic                 unused_count_bits;

  assign raw               = i_Count[3:0];
  assign folded            = (raw >= 4'd13) ? (raw - 4'd13) : raw;
  assign unused_count_bits = ^i_Count[WIDTH-1:4];
  assign shuffle_now       = (state_reg == ST_IDLE) && i_Shuffle;
  assign cand_full         = full_vec[cand_reg];

  // One saturating copy counter per rank; shuffle and reset empty them all.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANKS; gi++) begin : g_copies
      logic [2:0] copy_reg;

      always_ff @(posedge clk_50M) begin
        if (i_Reset || shuffle_now) begin
          copy_reg <= '0;
        end else if (state_reg == ST_DEAL && cand_reg == 4'(gi)) begin
          copy_reg <= copy_reg + 3'd1;
        end
      end

      assign full_vec[gi] = (copy_reg == COPY_LIMIT);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!i_Shuffle && i_Draw && !deck_empty_reg) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        cand_next  = folded;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        // Linear probe to the next rank; terminates because the deck is not empty.
        if (cand_full) begin
          cand_next = (cand_reg == LAST_CAND) ? 4'd0 : (cand_reg + 4'd1);
        end else begin
          state_next = ST_DEAL;
        end
      end
      ST_DEAL: begin
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_reg      <= ST_IDLE;
      cand_reg       <= '0;
      dealt_reg      <= '0;
      card_reg       <= '0;
      value_reg      <= '0;
      valid_reg      <= 1'b0;
      deck_empty_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      valid_reg <= 1'b0;
      if (shuffle_now) begin
        dealt_reg      <= '0;
        deck_empty_reg <= 1'b0;
      end
      // Card outputs are loaded on entry to DEAL so they are valid during it.
      if (state_reg == ST_CHECK && !cand_full) begin
        card_reg  <= cand_reg + 4'd1;
        value_reg <= rank_value(cand_reg + 4'd1);
        valid_reg <= 1'b1;
      end
      if (state_reg == ST_DEAL) begin
        dealt_reg      <= dealt_reg + 6'd1;
        deck_empty_reg <= ((dealt_reg + 6'd1) == DECK_FULL);
      end
    end
  end

  hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_timer (
    .clk_50M  (clk_50M),
    .i_Reset  (i_Reset),
    .start    (state_reg == ST_DEAL),
    .i_Tick2K (i_Tick2K),
    .done     (hold_done)
  );

  assign o_Card      = card_reg;
  assign o_Value     = value_reg;
  assign o_Valid     = valid_reg;
  assign o_Busy      = (state_reg != ST_IDLE);
  assign o_DeckEmpty = deck_empty_reg;
  assign o_TwoSec    = hold_done;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a deck model predicts each dealt card,
// its latency and the hold length; a monitor checks every DUT output pulse.
module tb_card_dealer;

  localparam int HOLD = 16;

  logic        clk_50M = 1'b0;
  logic        i_Reset;
  logic        i_Tick2K;
  logic [11:0] i_Count;
  logic        i_Draw;
  logic        i_Shuffle;
  logic [3:0]  o_Card;
  logic [3:0]  o_Value;
  logic        o_Valid;
  logic        o_Busy;
  logic        o_DeckEmpty;
  logic        o_TwoSec;

  card_dealer #(
    .WIDTH(12),
    .HOLD_TICKS(HOLD),
    .MAX_COPIES(4)
  ) dut (
    .clk_50M     (clk_50M),
    .i_Reset     (i_Reset),
    .i_Tick2K    (i_Tick2K),
    .i_Count     (i_Count),
    .i_Draw      (i_Draw),
    .i_Shuffle   (i_Shuffle),
    .o_Card      (o_Card),
    .o_Value     (o_Value),
    .o_Valid     (o_Valid),
    .o_Busy      (o_Busy),
    .o_DeckEmpty (o_DeckEmpty),
    .o_TwoSec    (o_TwoSec)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct packed {
    int card;
    int value;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_pushed = 0;
  int   model_cnt[13];
  int   model_dealt = 0;
  int   last_card = 0;
  int   seen_hist[13];
  int   tick_cnt = 0;
  bit   counting = 0;
  bit   arm = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 13; r++) model_cnt[r] = 0;
    model_dealt = 0;
  endtask

  // Free-running random 2 kHz strobe stand-in.
  initial begin
    i_Tick2K = 1'b0;
    forever begin
      @(negedge clk_50M);
      i_Tick2K = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: counts strobes in the hold window and scores every output pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50M);
      cyc++;
      if (i_Reset) begin
        counting = 0;
        arm      = 0;
      end else begin
        if (counting && i_Tick2K) tick_cnt++;
        if (arm) begin
          counting = 1;
          arm      = 0;
        end
      end
      #1;
      if (o_Valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got card %0d expected no deal", o_Card);
        end else begin
          e = exp_q.pop_front();
          check("card", int'(o_Card), e.card);
          check("value", int'(o_Value), e.value);
          check("latency", cyc, e.due);
        end
        if (o_Card >= 4'd1 && o_Card <= 4'd13) seen_hist[o_Card - 4'd1]++;
        counting = 0;
        arm      = 1;
        tick_cnt = 0;
      end
      if (o_TwoSec) begin
        if (counting) begin
          check("hold_ticks", tick_cnt, HOLD);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_twosec: got pulse expected none");
        end
        counting = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 4000) begin
      @(negedge clk_50M);
      n++;
    end
    check("idle_timeout", int'(o_Busy), 0);
  endtask

  // Issue one draw; the model predicts rank by scanning from raw mod 13.
  task automatic issue_draw(input logic [11:0] cnt);
    int  raw;
    int  start;
    int  k;
    int  r;
    bit  expect_deal;
    @(negedge clk_50M);
    i_Count     = cnt;
    i_Draw      = 1'b1;
    raw         = int'(cnt[3:0]);
    expect_deal = (model_dealt < 52);
    if (expect_deal) begin
      start = raw % 13;
      k     = 0;
      while (model_cnt[(start + k) % 13] >= 4) k++;
      r = (start + k) % 13;
      model_cnt[r]++;
      model_dealt++;
      last_card = r + 1;
      exp_q.push_back('{card: r + 1, value: (r + 1 > 10) ? 10 : r + 1, due: cyc + 3 + k});
      n_pushed++;
    end
    @(negedge clk_50M);
    i_Draw = 1'b0;
    check("busy_after_draw", int'(o_Busy), int'(expect_deal));
  endtask

  task automatic finish_draw();
    wait_idle();
    repeat (2) @(negedge clk_50M);
    check("pending_expect", exp_q.size(), 0);
    check("deck_empty", int'(o_DeckEmpty), int'(model_dealt == 52));
  endtask

  task automatic do_draw(input logic [11:0] cnt);
    issue_draw(cnt);
    finish_draw();
  endtask

  task automatic shuffle(input bit with_draw);
    @(negedge clk_50M);
    i_Shuffle = 1'b1;
    i_Draw    = with_draw;
    i_Count   = 12'($urandom);
    @(negedge clk_50M);
    i_Shuffle = 1'b0;
    i_Draw    = 1'b0;
    model_clear();
    check("shuffle_deck_empty", int'(o_DeckEmpty), 0);
    check("shuffle_busy", int'(o_Busy), 0);
    check("shuffle_keeps_card", int'(o_Card), last_card);
    repeat (4) @(negedge clk_50M);
    check("shuffle_no_deal_busy", int'(o_Busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_card"}, int'(o_Card), 0);
    check({tag, "_value"}, int'(o_Value), 0);
    check({tag, "_valid"}, int'(o_Valid), 0);
    check({tag, "_busy"}, int'(o_Busy), 0);
    check({tag, "_deck_empty"}, int'(o_DeckEmpty), 0);
    check({tag, "_twosec"}, int'(o_TwoSec), 0);
  endtask

  task automatic apply_reset();
    i_Reset = 1'b1;
    @(negedge clk_50M);
    i_Reset = 1'b0;
    model_clear();
    last_card = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 13; r++) seen_hist[r] = 0;
    model_clear();
    i_Reset   = 1'b1;
    i_Draw    = 1'b0;
    i_Shuffle = 1'b0;
    i_Count   = 12'h000;
    repeat (3) @(negedge clk_50M);
    i_Reset = 1'b0;
    check_reset_outputs("reset");

    do_draw(12'h005);
    check("t1_card", int'(o_Card), 6);
    check("t1_value", int'(o_Value), 6);
    do_draw(12'hA0E);
    check("fold_card", int'(o_Card), 2);
    do_draw(12'h00C);
    check("king_card", int'(o_Card), 13);
    check("king_value", int'(o_Value), 10);
    do_draw(12'h000);
    check("ace_card", int'(o_Card), 1);
    check("ace_value", int'(o_Value), 1);

    for (int i = 0; i < 4; i++) do_draw(12'(($urandom & 32'hFF0) | 32'h3));
    do_draw(12'h7F3);
    check("exhausted_card", int'(o_Card), 5);

    shuffle(1'b0);
    for (int r = 0; r < 13; r++) seen_hist[r] = 0;
    for (int i = 0; i < 52; i++) do_draw(12'($urandom));
    for (int r = 0; r < 13; r++) check($sformatf("rank%0d_count", r + 1), seen_hist[r], 4);
    check("deck_full_flag", int'(o_DeckEmpty), 1);
    do_draw(12'($urandom));
    check("empty_draw_busy", int'(o_Busy), 0);

    shuffle(1'b1);

    issue_draw(12'($urandom));
    repeat (6) @(negedge clk_50M);
    i_Draw = 1'b1;
    i_Shuffle = 1'b1;
    @(negedge clk_50M);
    i_Draw = 1'b0;
    i_Shuffle = 1'b0;
    finish_draw();
    check("hold_draw_count", n_valid, n_pushed);

    // Reset while the dealer is probing.
    @(negedge clk_50M);
    i_Count = 12'h004;
    i_Draw  = 1'b1;
    @(negedge clk_50M);
    i_Draw = 1'b0;
    @(negedge clk_50M);
    apply_reset();
    check_reset_outputs("reset_check");
    repeat (6) @(negedge clk_50M);
    check("reset_check_idle", int'(o_Busy), 0);

    // Reset during the hold window.
    issue_draw(12'h009);
    repeat (5) @(negedge clk_50M);
    check("in_hold_busy", int'(o_Busy), 1);
    apply_reset();
    check_reset_outputs("reset_hold");
    repeat (3 * HOLD) @(negedge clk_50M);
    check("reset_hold_idle", int'(o_Busy), 0);

    do_draw(12'h005);
    check("post_reset_card", int'(o_Card), 6);
    check("valid_total", n_valid, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
